// File: rtl/dcm_lock_ctrl_if.sv
// Signal bundle between the DCM lock sequencer and the DCM / clk_out-domain logic.
// The slave modport is the controller's side; master is the environment's side.
interface dcm_lock_ctrl_if;
    logic       dcm_locked;
    logic [7:0] dcm_status;
    logic       restart;
    logic       dcm_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [2:0] retry_cnt;

    modport master (
        output dcm_locked, dcm_status, restart,
        input  dcm_rst, sys_rst, ready, fail, retry_cnt
    );

    modport slave (
        input  dcm_locked, dcm_status, restart,
        output dcm_rst, sys_rst, ready, fail, retry_cnt
    );
endinterface

// File: rtl/dcm_lock_ctrl.sv
// DCM_SP reset/lock sequencer: pulses DCM RST, qualifies LOCKED, releases sys_rst, retries.
// Optional macro DCM_CTRL_STATUS_CHK_EN also treats CLKIN/CLKFX-stopped status as lock loss.
module dcm_lock_ctrl #(
    parameter int RST_CYCLES    = 3,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4
) (
    input  logic               clk_in,
    input  logic               rst,
    dcm_lock_ctrl_if.slave     bus
);

    localparam int CNT_MAX =
        (LOCK_TIMEOUT > STABLE_CYCLES) ?
            ((LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES) :
            ((STABLE_CYCLES > RST_CYCLES) ? STABLE_CYCLES : RST_CYCLES);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [2:0]         retry_reg, retry_next;
    logic [1:0]         lock_sync_reg;
    logic               locked_s;
    logic               lock_ok;
    logic               retry_evt;
    logic               dcm_rst_reg, sys_rst_reg, ready_reg, fail_reg;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            lock_sync_reg <= 2'b00;
        end else begin
            lock_sync_reg <= {lock_sync_reg[0], bus.dcm_locked};
        end
    end

    assign locked_s = lock_sync_reg[1];

`ifdef DCM_CTRL_STATUS_CHK_EN
    logic [1:0] stat_sync_reg;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            stat_sync_reg <= 2'b00;
        end else begin
            stat_sync_reg <= {stat_sync_reg[0], bus.dcm_status[1] | bus.dcm_status[2]};
        end
    end

    assign lock_ok = locked_s & ~stat_sync_reg[1];
`else
    logic unused_status;
    assign unused_status = ^bus.dcm_status;
    assign lock_ok       = locked_s;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        retry_next = retry_reg;
        retry_evt  = 1'b0;

        case (state_reg)
            S_HOLD: begin
                if (cnt_reg >= CNT_W'(RST_CYCLES - 1)) begin
                    state_next = S_WAIT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_WAIT: begin
                // The cycle that first sees lock counts toward the stability window.
                if (locked_s) begin
                    state_next = (STABLE_CYCLES <= 1) ? S_RUN : S_STABLE;
                    cnt_next   = CNT_W'(1);
                end else if (cnt_reg >= CNT_W'(LOCK_TIMEOUT - 1)) begin
                    retry_evt = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_STABLE: begin
                if (!lock_ok) begin
                    state_next = S_WAIT;
                    cnt_next   = '0;
                end else if (cnt_reg >= CNT_W'(STABLE_CYCLES - 1)) begin
                    state_next = S_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!lock_ok) begin
                    retry_evt = 1'b1;
                end
            end
            S_FAIL: begin
                state_next = S_FAIL;
            end
            default: begin
                state_next = S_HOLD;
                cnt_next   = '0;
            end
        endcase

        if (retry_evt) begin
            cnt_next = '0;
            if (retry_reg >= 3'(MAX_RETRIES)) begin
                state_next = S_FAIL;
            end else begin
                retry_next = retry_reg + 3'd1;
                state_next = S_HOLD;
            end
        end

        // restart overrides everything, including a retry taken in the same cycle.
        if (bus.restart) begin
            state_next = S_HOLD;
            cnt_next   = '0;
            retry_next = 3'd0;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_reg   <= S_HOLD;
            cnt_reg     <= '0;
            retry_reg   <= 3'd0;
            dcm_rst_reg <= 1'b1;
            sys_rst_reg <= 1'b1;
            ready_reg   <= 1'b0;
            fail_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            retry_reg   <= retry_next;
            dcm_rst_reg <= (state_next == S_HOLD) || (state_next == S_FAIL);
            sys_rst_reg <= (state_next != S_RUN);
            ready_reg   <= (state_next == S_RUN);
            fail_reg    <= (state_next == S_FAIL);
        end
    end

    assign bus.dcm_rst   = dcm_rst_reg;
    assign bus.sys_rst   = sys_rst_reg;
    assign bus.ready     = ready_reg;
    assign bus.fail      = fail_reg;
    assign bus.retry_cnt = retry_reg;

endmodule

// File: tb/tb_dcm_lock_ctrl.sv
// Directed bench for dcm_lock_ctrl with RST_CYCLES=3, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
// Cycle k is the interval after the k-th rising edge following reset release (cycle 0 precedes it).
module tb_dcm_lock_ctrl;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    int   cyc    = 0;
    int   tests  = 0;
    int   errors = 0;

    dcm_lock_ctrl_if bus();

    dcm_lock_ctrl #(
        .RST_CYCLES   (3),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (2)
    ) dut (
        .clk_in(clk_in),
        .rst   (rst),
        .bus   (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end else begin
            $display("[TB] ok   %s @cycle %0d: %0h", tag, cyc, got);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        @(posedge clk_in);
        #1;
        bus.dcm_locked = 1'b0;
        bus.dcm_status = 8'h00;
        bus.restart    = 1'b0;
        rst            = 1'b1;
        #2;
        check("rst_dcm_rst", {7'd0, bus.dcm_rst}, 8'd1);
        check("rst_sys_rst", {7'd0, bus.sys_rst}, 8'd1);
        check("rst_ready",   {7'd0, bus.ready},   8'd0);
        check("rst_fail",    {7'd0, bus.fail},    8'd0);
        check("rst_retry",   {5'd0, bus.retry_cnt}, 8'd0);
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        bus.dcm_locked = 1'b0;
        bus.dcm_status = 8'h00;
        bus.restart    = 1'b0;

        // Normal lock, then lock loss in RUN and relock.
        do_reset();
        run_to(2);  check("t1_dcm_rst_c2", {7'd0, bus.dcm_rst}, 8'd1);
        run_to(3);  check("t1_dcm_rst_c3", {7'd0, bus.dcm_rst}, 8'd0);
        run_to(10); bus.dcm_locked = 1'b1;
        run_to(19); check("t1_ready_c19", {7'd0, bus.ready}, 8'd0);
                    check("t1_sysrst_c19", {7'd0, bus.sys_rst}, 8'd1);
        run_to(20); check("t1_ready_c20", {7'd0, bus.ready}, 8'd1);
                    check("t1_sysrst_c20", {7'd0, bus.sys_rst}, 8'd0);
                    check("t1_retry", {5'd0, bus.retry_cnt}, 8'd0);
        run_to(25); bus.dcm_locked = 1'b0;
        run_to(27); check("t4_ready_c27", {7'd0, bus.ready}, 8'd1);
        run_to(28); check("t4_ready_c28", {7'd0, bus.ready}, 8'd0);
                    check("t4_sysrst_c28", {7'd0, bus.sys_rst}, 8'd1);
                    check("t4_dcmrst_c28", {7'd0, bus.dcm_rst}, 8'd1);
                    check("t4_retry", {5'd0, bus.retry_cnt}, 8'd1);
        run_to(30); check("t4_dcmrst_c30", {7'd0, bus.dcm_rst}, 8'd1);
        run_to(31); check("t4_dcmrst_c31", {7'd0, bus.dcm_rst}, 8'd0);
                    bus.dcm_locked = 1'b1;
        run_to(40); check("t4_ready_c40", {7'd0, bus.ready}, 8'd0);
        run_to(41); check("t4_ready_c41", {7'd0, bus.ready}, 8'd1);
                    check("t4_retry_c41", {5'd0, bus.retry_cnt}, 8'd1);

        // Never locks: three reset pulses then FAIL, then restart.
        do_reset();
        run_to(22); check("t2_dcmrst_c22", {7'd0, bus.dcm_rst}, 8'd0);
        run_to(23); check("t2_dcmrst_c23", {7'd0, bus.dcm_rst}, 8'd1);
                    check("t2_retry_c23", {5'd0, bus.retry_cnt}, 8'd1);
        run_to(26); check("t2_dcmrst_c26", {7'd0, bus.dcm_rst}, 8'd0);
        run_to(46); check("t2_dcmrst_c46", {7'd0, bus.dcm_rst}, 8'd1);
                    check("t2_retry_c46", {5'd0, bus.retry_cnt}, 8'd2);
        run_to(49); check("t2_dcmrst_c49", {7'd0, bus.dcm_rst}, 8'd0);
        run_to(68); check("t2_fail_c68", {7'd0, bus.fail}, 8'd0);
        run_to(69); check("t2_fail_c69", {7'd0, bus.fail}, 8'd1);
                    check("t2_dcmrst_c69", {7'd0, bus.dcm_rst}, 8'd1);
                    check("t2_sysrst_c69", {7'd0, bus.sys_rst}, 8'd1);
                    check("t2_retry_c69", {5'd0, bus.retry_cnt}, 8'd2);
        run_to(100); check("t2_fail_c100", {7'd0, bus.fail}, 8'd1);
                     check("t2_ready_c100", {7'd0, bus.ready}, 8'd0);
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        check("t5_fail_after", {7'd0, bus.fail}, 8'd0);
        check("t5_retry_after", {5'd0, bus.retry_cnt}, 8'd0);
        check("t5_dcmrst_after", {7'd0, bus.dcm_rst}, 8'd1);
        check("t5_sysrst_after", {7'd0, bus.sys_rst}, 8'd1);
        run_to(104); check("t5_dcmrst_c104", {7'd0, bus.dcm_rst}, 8'd0);

        // Restart coincident with the second lock timeout.
        do_reset();
        run_to(45); check("t5b_retry_c45", {5'd0, bus.retry_cnt}, 8'd1);
                    bus.restart = 1'b1;
        run_to(46); bus.restart = 1'b0;
                    check("t5b_retry_c46", {5'd0, bus.retry_cnt}, 8'd0);
                    check("t5b_fail_c46", {7'd0, bus.fail}, 8'd0);
                    check("t5b_dcmrst_c46", {7'd0, bus.dcm_rst}, 8'd1);
        run_to(49); check("t5b_dcmrst_c49", {7'd0, bus.dcm_rst}, 8'd0);

        // One-cycle lock glitch during STABLE.
        do_reset();
        run_to(10); bus.dcm_locked = 1'b1;
        run_to(15); bus.dcm_locked = 1'b0;
        run_to(16); bus.dcm_locked = 1'b1;
        run_to(20); check("t3_ready_c20", {7'd0, bus.ready}, 8'd0);
        run_to(25); check("t3_ready_c25", {7'd0, bus.ready}, 8'd0);
        run_to(26); check("t3_ready_c26", {7'd0, bus.ready}, 8'd1);
                    check("t3_retry_c26", {5'd0, bus.retry_cnt}, 8'd0);

        // CLKIN-stopped status while in RUN.
        do_reset();
        run_to(10); bus.dcm_locked = 1'b1;
        run_to(20); check("t6_ready_c20", {7'd0, bus.ready}, 8'd1);
        run_to(22); bus.dcm_status = 8'h02;
        run_to(25);
`ifdef DCM_CTRL_STATUS_CHK_EN
        check("t6_ready_c25", {7'd0, bus.ready}, 8'd0);
        check("t6_sysrst_c25", {7'd0, bus.sys_rst}, 8'd1);
        check("t6_dcmrst_c25", {7'd0, bus.dcm_rst}, 8'd1);
        check("t6_retry_c25", {5'd0, bus.retry_cnt}, 8'd1);
`else
        check("t6_ready_c25", {7'd0, bus.ready}, 8'd1);
        check("t6_sysrst_c25", {7'd0, bus.sys_rst}, 8'd0);
        check("t6_retry_c25", {5'd0, bus.retry_cnt}, 8'd0);
`endif
        bus.dcm_status = 8'h00;
        run_to(30);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
